// File: rtl/vga_vram_arbiter_if.sv
// CPU-side request/response bundle for the text-mode VRAM arbiter.
//
// Handshake: a request (cpu_we/cpu_addr/cpu_wdata) is transferred on every
// rising pclk edge where cpu_req && cpu_ready are both high. The requester
// must hold cpu_req and its payload stable until that edge. cpu_ready does
// not depend on cpu_req. Responses carry no back-pressure. cpu_rvalid pulses
// for one cycle with cpu_rdata. cpu_err pulses for one cycle when the request
// addressed a cell beyond the end of the RAM.
//
// Signals:
//   cpu_req, cpu_we, cpu_addr[AW], cpu_wdata[DW]   master -> slave
//   cpu_ready, cpu_rvalid, cpu_rdata[DW], cpu_err  slave  -> master
interface vga_vram_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_err;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_err
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rvalid, cpu_rdata, cpu_err
    );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Text-mode VRAM arbiter. It shares one single-port synchronous RAM (80x30
// cells, 16-bit words) between display scan-out and a CPU port. The display
// fetches one cell on every active pixel with h_addr[2:0]==0 and always wins.
// The CPU owns every other cycle through a one-entry pending register.
//
// Ports:
//   pclk, reset                 clock, synchronous active-high reset
//   vid_valid, h_addr, v_addr   pixel position from the timing generator
//   cpu                         CPU request/response bundle (slave side)
//   vram_en/we/addr/wdata       combinational RAM controls
//   vram_rdata                  RAM read data, one cycle after vram_en
//   out_valid/out_cell/out_px/out_row
//                               display stream, 2 cycles behind the inputs
module vga_vram_arbiter #(
    parameter int COLS  = 80,
    parameter int ROWS  = 30,
    parameter int DEPTH = COLS * ROWS,
    parameter int AW    = 12,
    parameter int DW    = 16
) (
    input  logic                 pclk,
    input  logic                 reset,
    input  logic                 vid_valid,
    input  logic [9:0]           h_addr,
    input  logic [9:0]           v_addr,
    vga_vram_arbiter_if.slave    cpu,
    output logic                 vram_en,
    output logic                 vram_we,
    output logic [AW-1:0]        vram_addr,
    output logic [DW-1:0]        vram_wdata,
    input  logic [DW-1:0]        vram_rdata,
    output logic                 out_valid,
    output logic [DW-1:0]        out_cell,
    output logic [2:0]           out_px,
    output logic [3:0]           out_row
);
    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

    // The display address uses a shift-add that only works for 80 columns.
    if (COLS != 80 || DEPTH != COLS * ROWS || DEPTH > (1 << AW)) begin : g_bad_cfg
        $error("vga_vram_arbiter: unsupported COLS/ROWS/DEPTH/AW combination");
    end

    logic          pend_valid;
    logic          pend_we;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_wdata;

    logic          slot;
    logic          grant;
    logic          accept;
    logic          pend_in_range;
    logic [AW-1:0] row_w;
    logic [AW-1:0] col_w;
    logic [AW-1:0] disp_addr;

    logic          rd_d1;
    logic          rd_oor_d1;
    logic          slot_d1;
    logic          vv_d1;
    logic [2:0]    px_d1;
    logic [3:0]    row_d1;

    // Only rows 0..29 are addressed, so v_addr[9] never matters.
    logic unused_v9;
    assign unused_v9 = v_addr[9];

    assign slot          = vid_valid && (h_addr[2:0] == 3'd0);
    assign row_w         = AW'(v_addr[8:4]);
    assign col_w         = AW'(h_addr[9:3]);
    assign disp_addr     = (row_w << 6) + (row_w << 4) + col_w;   // row*80 + col
    assign pend_in_range = pend_addr < DEPTH_W;
    assign grant         = pend_valid && !slot;
    assign accept        = cpu.cpu_req && !pend_valid;
    assign cpu.cpu_ready = !pend_valid;

    // Display slot first. An out-of-range grant still retires the request,
    // but it leaves the RAM disabled.
    always_comb begin
        vram_en    = 1'b0;
        vram_we    = 1'b0;
        vram_addr  = '0;
        vram_wdata = '0;
        if (slot) begin
            vram_en   = 1'b1;
            vram_addr = disp_addr;
        end else if (grant && pend_in_range) begin
            vram_en    = 1'b1;
            vram_we    = pend_we;
            vram_addr  = pend_addr;
            vram_wdata = pend_wdata;
        end
    end

    // Accept and grant are mutually exclusive, because accept needs !pend_valid.
    always_ff @(posedge pclk) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_we    <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= '0;
        end else if (accept) begin
            pend_valid <= 1'b1;
            pend_we    <= cpu.cpu_we;
            pend_addr  <= cpu.cpu_addr;
            pend_wdata <= cpu.cpu_wdata;
        end else if (grant) begin
            pend_valid <= 1'b0;
        end
    end

    // CPU response pipeline. A read granted at g has RAM data at g+1 and is
    // reported at g+2. An out-of-range read reports zero instead of the RAM bus.
    always_ff @(posedge pclk) begin
        if (reset) begin
            rd_d1          <= 1'b0;
            rd_oor_d1      <= 1'b0;
            cpu.cpu_rvalid <= 1'b0;
            cpu.cpu_rdata  <= '0;
            cpu.cpu_err    <= 1'b0;
        end else begin
            rd_d1          <= grant && !pend_we;
            rd_oor_d1      <= grant && !pend_we && !pend_in_range;
            cpu.cpu_err    <= grant && !pend_in_range;
            cpu.cpu_rvalid <= rd_d1;
            if (rd_d1) begin
                cpu.cpu_rdata <= rd_oor_d1 ? '0 : vram_rdata;
            end
        end
    end

    // Display pipeline. out_cell is loaded only from display fetches, so a
    // CPU read on the RAM bus never disturbs it.
    always_ff @(posedge pclk) begin
        if (reset) begin
            slot_d1   <= 1'b0;
            vv_d1     <= 1'b0;
            px_d1     <= '0;
            row_d1    <= '0;
            out_valid <= 1'b0;
            out_px    <= '0;
            out_row   <= '0;
            out_cell  <= '0;
        end else begin
            slot_d1   <= slot;
            vv_d1     <= vid_valid;
            px_d1     <= h_addr[2:0];
            row_d1    <= v_addr[3:0];
            out_valid <= vv_d1;
            out_px    <= px_d1;
            out_row   <= row_d1;
            if (slot_d1) begin
                out_cell <= vram_rdata;
            end
        end
    end
endmodule

// File: tb/tb_vga_vram_arbiter.sv
module tb_vga_vram_arbiter;
    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int DEPTH = 2400;

    logic          pclk = 1'b0;
    logic          reset;
    logic          vid_valid;
    logic [9:0]    h_addr;
    logic [9:0]    v_addr;
    logic          vram_en;
    logic          vram_we;
    logic [AW-1:0] vram_addr;
    logic [DW-1:0] vram_wdata;
    logic [DW-1:0] vram_rdata = '0;
    logic          out_valid;
    logic [DW-1:0] out_cell;
    logic [2:0]    out_px;
    logic [3:0]    out_row;

    vga_vram_arbiter_if #(.AW(AW), .DW(DW)) cpu_if ();

    vga_vram_arbiter #(.COLS(80), .ROWS(30), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .pclk       (pclk),
        .reset      (reset),
        .vid_valid  (vid_valid),
        .h_addr     (h_addr),
        .v_addr     (v_addr),
        .cpu        (cpu_if.slave),
        .vram_en    (vram_en),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata),
        .out_valid  (out_valid),
        .out_cell   (out_cell),
        .out_px     (out_px),
        .out_row    (out_row)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [DW-1:0] ram [DEPTH] = '{default: '0};
    logic [DW-1:0] exp_q [$];

    // ---------------- clock ----------------
    always #5 pclk = ~pclk;

    // Synchronous single-port RAM that the arbiter drives.
    always @(posedge pclk) begin
        if (vram_en && (int'(vram_addr) < DEPTH)) begin
            if (vram_we) ram[vram_addr] <= vram_wdata;
            vram_rdata <= ram[vram_addr];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_vid(input logic vv, input logic [9:0] h, input logic [9:0] v);
        vid_valid = vv;
        h_addr    = h;
        v_addr    = v;
    endtask

    // Presents a request and holds it until it is accepted (at most 8 cycles).
    // The task returns just after the accept edge with cpu_req dropped.
    task automatic cpu_send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            output logic ok);
        ok = 1'b0;
        cpu_if.cpu_req   = 1'b1;
        cpu_if.cpu_we    = we;
        cpu_if.cpu_addr  = a;
        cpu_if.cpu_wdata = d;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (cpu_if.cpu_ready === 1'b1) begin
                ok = 1'b1;
                cyc();
                break;
            end
            cyc();
        end
        cpu_if.cpu_req = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        set_vid(1'b0, 10'd0, 10'd0);
        cpu_if.cpu_req = 1'b1; cpu_if.cpu_we = 1'b1;
        cpu_if.cpu_addr = 12'd3; cpu_if.cpu_wdata = 16'hFFFF;
        cyc();
        n_cmp++; if (vram_en !== 1'b0) begin n_fail++; $display("FAIL reset_en_during: got %b want 0", vram_en); end
        cyc();
        reset = 1'b0;
        cpu_if.cpu_req = 1'b0;
        #1;
        n_cmp++; if (cpu_if.cpu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cpu_if.cpu_ready); end
        n_cmp++; if (vram_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b want 0", vram_en); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_cell !== 16'h0) begin n_fail++; $display("FAIL reset_out_cell: got %h want 0", out_cell); end
        n_cmp++; if (out_px !== 3'd0) begin n_fail++; $display("FAIL reset_out_px: got %0d want 0", out_px); end
        n_cmp++; if (out_row !== 4'd0) begin n_fail++; $display("FAIL reset_out_row: got %0d want 0", out_row); end
        n_cmp++; if (cpu_if.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b want 0", cpu_if.cpu_rvalid); end
        n_cmp++; if (cpu_if.cpu_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", cpu_if.cpu_rdata); end
        n_cmp++; if (cpu_if.cpu_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", cpu_if.cpu_err); end
        cyc();
    endtask

    task automatic test_blank_rw();
        logic ok;
        cpu_send(1'b1, 12'd5, 16'hA341, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL blank_wr_accept: got %b want 1", ok); end
        #1;
        n_cmp++; if ({vram_en, vram_we} !== 2'b11) begin n_fail++; $display("FAIL blank_wr_en_we: got %b want 11", {vram_en, vram_we}); end
        n_cmp++; if (vram_addr !== 12'd5) begin n_fail++; $display("FAIL blank_wr_addr: got %0d want 5", vram_addr); end
        n_cmp++; if (vram_wdata !== 16'hA341) begin n_fail++; $display("FAIL blank_wr_data: got %h want a341", vram_wdata); end
        n_cmp++; if (cpu_if.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL blank_wr_busy: got %b want 0", cpu_if.cpu_ready); end
        cyc();
        n_cmp++; if (cpu_if.cpu_ready !== 1'b1) begin n_fail++; $display("FAIL blank_wr_ready_back: got %b want 1", cpu_if.cpu_ready); end
        n_cmp++; if (vram_en !== 1'b0) begin n_fail++; $display("FAIL blank_idle_en: got %b want 0", vram_en); end
        cpu_send(1'b0, 12'd5, 16'h0, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL blank_rd_accept: got %b want 1", ok); end
        #1;
        n_cmp++; if ({vram_en, vram_we, vram_addr} !== {2'b10, 12'd5}) begin n_fail++; $display("FAIL blank_rd_grant: got en=%b we=%b addr=%0d want en=1 we=0 addr=5", vram_en, vram_we, vram_addr); end
        cyc();
        n_cmp++; if (cpu_if.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL blank_rd_early: got %b want 0", cpu_if.cpu_rvalid); end
        cyc();
        n_cmp++; if (cpu_if.cpu_rvalid !== 1'b1) begin n_fail++; $display("FAIL blank_rd_rvalid: got %b want 1", cpu_if.cpu_rvalid); end
        n_cmp++; if (cpu_if.cpu_rdata !== 16'hA341) begin n_fail++; $display("FAIL blank_rd_data: got %h want a341", cpu_if.cpu_rdata); end
        cyc();
        n_cmp++; if (cpu_if.cpu_rvalid !== 1'b0) begin n_fail++; $display("FAIL blank_rd_pulse: got %b want 0", cpu_if.cpu_rvalid); end
    endtask

    task automatic test_display();
        logic ok;
        cpu_send(1'b1, 12'd81, 16'h1F41, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL disp_preload: got %b want 1", ok); end
        cyc(); cyc();
        for (int i = 0; i < 10; i++) begin
            set_vid(1'b1, 10'(8 + i), 10'd16);
            #1;
            if (i == 0) begin
                n_cmp++; if ({vram_en, vram_we, vram_addr} !== {2'b10, 12'd81}) begin n_fail++; $display("FAIL disp_fetch: got en=%b we=%b addr=%0d want en=1 we=0 addr=81", vram_en, vram_we, vram_addr); end
            end
            if (i >= 2) begin
                n_cmp++; if (out_cell !== 16'h1F41) begin n_fail++; $display("FAIL disp_cell[%0d]: got %h want 1f41", i, out_cell); end
                n_cmp++; if (out_px !== 3'(i - 2)) begin n_fail++; $display("FAIL disp_px[%0d]: got %0d want %0d", i, out_px, i - 2); end
                n_cmp++; if ({out_valid, out_row} !== 5'b1_0000) begin n_fail++; $display("FAIL disp_valid_row[%0d]: got %b/%0d want 1/0", i, out_valid, out_row); end
            end
            cyc();
        end
        set_vid(1'b0, 10'd0, 10'd0);
        cyc(); cyc();
    endtask

    task automatic test_collision();
        logic ok;
        set_vid(1'b1, 10'd6, 10'd32);
        cpu_send(1'b1, 12'd7, 16'hBEEF, ok);
        n_cmp++; if (ok !== 1'b1) begin n_fail++; $display("FAIL coll_accept: got %b want 1", ok); end
        set_vid(1'b1, 10'd8, 10'd32);
        #1;
        n_cmp++; if ({vram_en, vram_we, vram_addr} !== {2'b10, 12'd161}) begin n_fail++; $display("FAIL coll_display_wins: got en=%b we=%b addr=%0d want en=1 we=0 addr=161", vram_en, vram_we, vram_addr); end
        n_cmp++; if (cpu_if.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL coll_busy1: got %b want 0", cpu_if.cpu_ready); end
        cyc();
        set_vid(1'b1, 10'd9, 10'd32);
        #1;
        n_cmp++; if ({vram_en, vram_we, vram_addr, vram_wdata} !== {2'b11, 12'd7, 16'hBEEF}) begin n_fail++; $display("FAIL coll_cpu_grant: got en=%b we=%b addr=%0d data=%h want 1/1/7/beef", vram_en, vram_we, vram_addr, vram_wdata); end
        n_cmp++; if (cpu_if.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL coll_busy2: got %b want 0", cpu_if.cpu_ready); end
        cyc();
        set_vid(1'b1, 10'd10, 10'd32);
        #1;
        n_cmp++; if (cpu_if.cpu_ready !== 1'b1) begin n_fail++; $display("FAIL coll_ready_back: got %b want 1", cpu_if.cpu_ready); end
        cyc();
        set_vid(1'b0, 10'd0, 10'd0);
        cpu_send(1'b0, 12'd7, 16'h0, ok);
        cyc(); cyc();
        n_cmp++; if ({cpu_if.cpu_rvalid, cpu_if.cpu_rdata} !== {1'b1, 16'hBEEF}) begin n_fail++; $display("FAIL coll_readback: got %b/%h want 1/beef", cpu_if.cpu_rvalid, cpu_if.cpu_rdata); end
        cyc();
    endtask

    task automatic test_out_of_range();
        logic ok;
        cpu_send(1'b1, 12'd2400, 16'h1234, ok);
        #1;
        n_cmp++; if (vram_en !== 1'b0) begin n_fail++; $display("FAIL oor_wr_en: got %b want 0", vram_en); end
        n_cmp++; if (cpu_if.cpu_ready !== 1'b0) begin n_fail++; $display("FAIL oor_wr_busy: got %b want 0", cpu_if.cpu_ready); end
        cyc();
        n_cmp++; if ({cpu_if.cpu_err, cpu_if.cpu_ready} !== 2'b11) begin n_fail++; $display("FAIL oor_wr_err: got err=%b ready=%b want 1/1", cpu_if.cpu_err, cpu_if.cpu_ready); end
        cyc();
        n_cmp++; if (cpu_if.cpu_err !== 1'b0) begin n_fail++; $display("FAIL oor_wr_err_pulse: got %b want 0", cpu_if.cpu_err); end
        cpu_send(1'b0, 12'd4095, 16'h0, ok);
        #1;
        n_cmp++; if (vram_en !== 1'b0) begin n_fail++; $display("FAIL oor_rd_en: got %b want 0", vram_en); end
        cyc();
        n_cmp++; if ({cpu_if.cpu_err, cpu_if.cpu_rvalid} !== 2'b10) begin n_fail++; $display("FAIL oor_rd_err: got err=%b rvalid=%b want 1/0", cpu_if.cpu_err, cpu_if.cpu_rvalid); end
        cyc();
        n_cmp++; if ({cpu_if.cpu_rvalid, cpu_if.cpu_rdata, cpu_if.cpu_err} !== {1'b1, 16'h0, 1'b0}) begin n_fail++; $display("FAIL oor_rd_data: got rvalid=%b rdata=%h err=%b want 1/0000/0", cpu_if.cpu_rvalid, cpu_if.cpu_rdata, cpu_if.cpu_err); end
        cyc();
    endtask

    task automatic test_reset_mid_read();
        logic ok;
        cpu_send(1'b0, 12'd5, 16'h0, ok);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if ({cpu_if.cpu_rvalid, cpu_if.cpu_err} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_resp[%0d]: got rvalid=%b err=%b want 0/0", i, cpu_if.cpu_rvalid, cpu_if.cpu_err); end
            n_cmp++; if (cpu_if.cpu_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready[%0d]: got %b want 1", i, cpu_if.cpu_ready); end
            cyc();
        end
    endtask

    // Random CPU traffic against a random scan pattern. The model keeps a
    // shadow of memory contents in request order. It uses row*80+col for
    // display fetches and holds each fetched cell for the display stream.
    task automatic test_random();
        logic [DW-1:0] shadow [DEPTH];
        int line_left = 0, gap_left = 0, x = 0, y = 0;
        logic holding = 1'b0, busy = 1'b0, cell_known = 1'b0;
        int wait_cnt = 0, err_exp = 0, err_seen = 0;
        logic          d1_vv = 1'b0, d2_vv = 1'b0, d1_slot = 1'b0, d2_slot = 1'b0;
        logic [9:0]    d1_h = '0, d2_h = '0, d1_v = '0, d2_v = '0;
        logic [DW-1:0] d1_val = '0, d2_val = '0, exp_cell = '0, cur_val;
        logic          cur_slot;
        int            exp_addr;
        for (int i = 0; i < DEPTH; i++) shadow[i] = ram[i];
        for (int cyc_n = 0; cyc_n < 700; cyc_n++) begin
            // scan generator: short active runs separated by blanking
            if (line_left == 0 && gap_left == 0) begin
                if ($urandom_range(0, 1) == 0) begin
                    x = $urandom_range(0, 590); y = $urandom_range(0, 479);
                end else begin
                    x = $urandom_range(0, 200); y = $urandom_range(0, 15);
                end
                line_left = $urandom_range(16, 48);
                gap_left  = $urandom_range(1, 6);
            end
            if (line_left > 0) begin
                set_vid(1'b1, 10'(x), 10'(y)); x++; line_left--;
            end else begin
                set_vid(1'b0, 10'd0, 10'd0); gap_left--;
            end
            // CPU requester, silent for the final drain cycles
            if (!holding && cyc_n < 680 && $urandom_range(0, 1) == 1) begin
                holding = 1'b1;
                cpu_if.cpu_req   = 1'b1;
                cpu_if.cpu_we    = 1'($urandom_range(0, 1));
                cpu_if.cpu_wdata = 16'($urandom);
                case ($urandom_range(0, 7))
                    0:       cpu_if.cpu_addr = 12'($urandom_range(2400, 4095));
                    1, 2, 3: cpu_if.cpu_addr = 12'($urandom_range(0, 31));
                    default: cpu_if.cpu_addr = 12'($urandom_range(0, 2399));
                endcase
            end
            #1;
            // display stream, two cycles behind the scan inputs
            if (d2_slot) begin exp_cell = d2_val; cell_known = 1'b1; end
            n_cmp++; if ({out_valid, out_px, out_row} !== {d2_vv, d2_h[2:0], d2_v[3:0]}) begin n_fail++; $display("FAIL rnd_out_pos@%0d: got %b/%0d/%0d want %b/%0d/%0d", cyc_n, out_valid, out_px, out_row, d2_vv, d2_h[2:0], d2_v[3:0]); end
            if (cell_known) begin
                n_cmp++; if (out_cell !== exp_cell) begin n_fail++; $display("FAIL rnd_out_cell@%0d: got %h want %h", cyc_n, out_cell, exp_cell); end
            end
            cur_slot = vid_valid && (h_addr % 8 == 0);
            cur_val  = '0;
            if (cur_slot) begin
                exp_addr = int'(v_addr[8:4]) * 80 + int'(h_addr) / 8;
                cur_val  = ram[exp_addr];
                n_cmp++; if ({vram_en, vram_we, vram_addr} !== {2'b10, 12'(exp_addr)}) begin n_fail++; $display("FAIL rnd_slot@%0d: got en=%b we=%b addr=%0d want 1/0/%0d", cyc_n, vram_en, vram_we, vram_addr, exp_addr); end
            end
            // accept-to-ready is bounded by one display stall
            if (busy) begin
                if (cpu_if.cpu_ready === 1'b1) busy = 1'b0;
                else begin
                    wait_cnt++;
                    n_cmp++; if (wait_cnt > 2) begin n_fail++; $display("FAIL rnd_stall@%0d: got %0d busy cycles want <=2", cyc_n, wait_cnt); end
                end
            end
            if (cpu_if.cpu_rvalid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_fail++; $display("FAIL rnd_rvalid@%0d: got spurious pulse want none", cyc_n); end
                else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    if (cpu_if.cpu_rdata !== e) begin n_fail++; $display("FAIL rnd_rdata@%0d: got %h want %h", cyc_n, cpu_if.cpu_rdata, e); end
                end
            end
            if (cpu_if.cpu_err === 1'b1) err_seen++;
            if (holding && cpu_if.cpu_ready === 1'b1) begin
                if (int'(cpu_if.cpu_addr) >= DEPTH) begin
                    err_exp++;
                    if (!cpu_if.cpu_we) exp_q.push_back('0);
                end else if (cpu_if.cpu_we) begin
                    shadow[cpu_if.cpu_addr] = cpu_if.cpu_wdata;
                end else begin
                    exp_q.push_back(shadow[cpu_if.cpu_addr]);
                end
                busy = 1'b1; wait_cnt = 0;
            end
            d2_vv = d1_vv; d2_h = d1_h; d2_v = d1_v; d2_slot = d1_slot; d2_val = d1_val;
            d1_vv = vid_valid; d1_h = h_addr; d1_v = v_addr; d1_slot = cur_slot; d1_val = cur_val;
            cyc();
            if (holding && busy && wait_cnt == 0 && cpu_if.cpu_ready === 1'b0) begin
                holding = 1'b0;
                cpu_if.cpu_req = 1'b0;
            end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rnd_drain: got %0d reads outstanding want 0", exp_q.size()); end
        n_cmp++; if (err_seen != err_exp) begin n_fail++; $display("FAIL rnd_err_count: got %0d want %0d", err_seen, err_exp); end
        cpu_if.cpu_req = 1'b0;
        set_vid(1'b0, 10'd0, 10'd0);
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        cpu_if.cpu_req = 1'b0; cpu_if.cpu_we = 1'b0;
        cpu_if.cpu_addr = '0; cpu_if.cpu_wdata = '0;
        test_reset();
        test_blank_rw();
        test_display();
        test_collision();
        test_out_of_range();
        test_reset_mid_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_vram_arbiter.md
# vga_vram_arbiter

Owns the single-port text-mode video RAM (80×30 cells, 16-bit cell word) and shares it between the display scan-out and CPU read/write requests. It sits between the VGA timing generator (which supplies `vid_valid`/`h_addr`/`v_addr`) and the font/colour stage. It guarantees one display fetch per 8-pixel character cell and gives every other cycle to the CPU. Display reads have absolute priority. CPU access uses a valid/ready handshake with a one-entry pending register.

## Interface

**Parameters**
- `COLS`, 80, character columns per line (8 px per cell)
- `ROWS`, 30, character rows per frame (16 px per cell)
- `DEPTH`, 2400, VRAM words (`COLS*ROWS`); valid addresses are 0..DEPTH-1
- `AW`, 12, VRAM address width
- `DW`, 16, cell word width: [7:0] char code, [11:8] fg index, [15:12] bg index

**Ports**
- `pclk`  in  1  pixel clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high
- `vid_valid`  in  1  active-region flag from the timing generator
- `h_addr`  in  10  active pixel x (0..639); 0 outside the active region
- `v_addr`  in  10  active pixel y (0..479); 0 outside the active region
- `cpu_req`  in  1  CPU request valid
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  AW  cell address
- `cpu_wdata`  in  DW  write data
- `cpu_ready`  out  1  request accepted on a cycle where `cpu_req && cpu_ready`
- `cpu_rvalid`  out  1  one-cycle pulse, read data valid
- `cpu_rdata`  out  DW  read data, valid with `cpu_rvalid`
- `cpu_err`  out  1  one-cycle pulse: accepted request had `cpu_addr >= DEPTH`
- `vram_en`  out  1  RAM enable (combinational)
- `vram_we`  out  1  RAM write enable (combinational)
- `vram_addr`  out  AW  RAM address (combinational)
- `vram_wdata`  out  DW  RAM write data (combinational)
- `vram_rdata`  in  DW  RAM read data; sync RAM, valid the cycle after `vram_en`
- `out_valid`  out  1  `vid_valid` delayed 2 cycles
- `out_cell`  out  DW  cell word for the current pixel
- `out_px`  out  3  `h_addr[2:0]` delayed 2 cycles (font column)
- `out_row`  out  4  `v_addr[3:0]` delayed 2 cycles (font row)

## Operation

**Display slot**
- A display slot is any cycle with `vid_valid && h_addr[2:0]==0`.
- In a display slot: `vram_en=1`, `vram_we=0`, `vram_addr = v_addr[8:4]*80 + h_addr[9:3]`.
- The address is computed as `(row<<6)+(row<<4)+col` in AW bits; the maximum value is 2399.

**CPU pending register** (`pend_valid`, `pend_we`, `pend_addr`, `pend_wdata`)
- `cpu_ready = !pend_valid`.
- On acceptance, the request is loaded into the pending register. `pend_valid` is set next cycle.

**CPU grant**
- The CPU is granted on any cycle with `pend_valid` that is not a display slot.
- On grant: `vram_en=1`, `vram_we=pend_we`, `vram_addr=pend_addr`, `vram_wdata=pend_wdata`. `pend_valid` clears at the end of the cycle.

**Out-of-range requests**
- If `pend_addr >= DEPTH`, the grant cycle drives `vram_en=0`.
- `pend_valid` still clears.
- `cpu_err` pulses in the cycle after the grant.
- A read in this case returns `cpu_rvalid=1` with `cpu_rdata=0` two cycles after the grant.

**Other cycles**
- With no slot and no grant: `vram_en=0`, `vram_we=0`, `vram_addr=0`, `vram_wdata=0`.

**Display data**
- `vram_rdata` from a display slot is registered into `out_cell` the following cycle.
- `out_cell` holds until the next display fetch returns, i.e. for 8 pixels.

**Reset**
- Reset clears `pend_valid`, so any in-flight request is discarded with no `cpu_rvalid`/`cpu_err`.
- All outputs read 0 in the cycle after reset: `cpu_ready` reads 1 once reset is released, and `out_cell`, `out_valid`, `out_px`, `out_row`, `cpu_rvalid`, `cpu_rdata`, `cpu_err` are all 0.

## Timing

**Display path**
- A slot at cycle t puts data on `vram_rdata` at t+1.
- `out_cell` updates at t+2, aligned with `out_px==0`.
- Fixed latency is 2 cycles for `out_*` relative to `vid_valid`/`h_addr`/`v_addr`.

**CPU write**
- Accept at t; grant earliest at t+1; RAM written at the end of the grant cycle.
- `cpu_ready` returns high in the cycle after the grant.

**CPU read**
- Grant at g; `vram_rdata` valid at g+1.
- `cpu_rvalid`/`cpu_rdata` registered, high in g+2 only.

**Throughput and stalls**
- Peak throughput is one accepted request per 2 cycles.
- If t+1 is a display slot, the grant slips to t+2.
- Worst-case accept-to-grant is 2 cycles, since display slots are never adjacent.

**Write/fetch ordering**
- A CPU write and a display fetch never share a cycle.
- A write to a cell is visible to the next fetch of that cell.

## Test plan

- **Reset:** assert `reset` 2 cycles with `cpu_req=1` → `cpu_ready=1` after release, no `vram_en`, all `out_*`=0.
- **CPU write/read in blanking:** with `vid_valid=0`, write addr 5 data 16'hA341, then read addr 5 → `vram_we` pulse 1 cycle after accept; `cpu_rvalid` with `cpu_rdata=16'hA341` 3 cycles after read accept.
- **Display scan:** preload cell 81=16'h1F41, drive `v_addr=16`, `h_addr` 8..15 with `vid_valid=1` → `vram_addr=81` at `h_addr=8`; `out_cell=16'h1F41` for 8 cycles starting 2 cycles later, with `out_px` 0..7 and `out_row=0`.
- **Collision:** accept a CPU write such that the next cycle has `h_addr[2:0]==0` → the display read wins at addr `row*80+col`, the CPU write is granted one cycle later, and `cpu_ready` stays low until then.
- **Out of range:** write to addr 2400 → no `vram_en` asserted, `cpu_err` pulse; read of 4095 → `cpu_err` plus `cpu_rvalid` with `cpu_rdata=0`.
- **Reset mid-read:** accept a read, assert `reset` on the grant cycle → no `cpu_rvalid`, `pend_valid` cleared.
